// File: rtl/pds_pkg.sv
// Shared types and constants for the packet data switch egress path.
package pds_pkg;

  localparam int SRC_W  = 4;
  localparam int TGT_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [TGT_W-1:0] BCAST_ID_DEFAULT = 4'hF;

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [TGT_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } pds_pkt_t;

  // A port takes packets aimed at itself or at the broadcast address.
  function automatic logic pds_accepts(input logic [TGT_W-1:0] target,
                                       input logic [TGT_W-1:0] my_id,
                                       input logic [TGT_W-1:0] bcast_id);
    return (target == my_id) || (target == bcast_id);
  endfunction

endpackage

// File: rtl/pds_sync_fifo.sv
// Single-clock FIFO; full/empty come from the occupancy count so the
// pointers can wrap freely and push+pop is legal even when full.
module pds_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pds_egress_buffer.sv
// Egress stage: filters the switch output by target ID, buffers accepted
// packets and hands them to a ready/valid consumer, counting overflow drops.
module pds_egress_buffer
  import pds_pkg::*;
#(
  parameter int               DEPTH    = 8,
  parameter logic [TGT_W-1:0] MY_ID    = 4'h1,
  parameter logic [TGT_W-1:0] BCAST_ID = BCAST_ID_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             data_in,
  input  logic                    valid_in,
  output logic [SRC_W-1:0]        pkt_source,
  output logic [DATA_W-1:0]       pkt_data,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              drop_cnt,
  output logic                    overflow
);

  pds_pkt_t pkt;
  logic     match;
  logic     push;
  logic     pop;
  logic     drop;
  logic     full;
  logic     empty;

  assign pkt       = data_in;
  assign match     = valid_in & pds_accepts(pkt.target, MY_ID, BCAST_ID);
  assign pkt_valid = ~empty;
  assign pop       = pkt_valid & pkt_ready;
  assign push      = match & (~full | pop);
  assign drop      = match & full & ~pop;

  pds_sync_fifo #(
    .WIDTH (SRC_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({pkt.source, pkt.data}),
    .rd_data ({pkt_source, pkt_data}),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // Drop counter saturates so a long overflow burst never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pds_egress_buffer.sv
// Directed bench with a queue scoreboard and a small occupancy/drop model.
module tb_pds_egress_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        valid_in;
  logic [3:0]  pkt_source;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int tests    = 0;
  int failures = 0;

  logic [11:0] sb_q[$];
  int          m_drops = 0;
  logic        m_ovf   = 1'b0;

  pds_egress_buffer #(
    .DEPTH    (DEPTH),
    .MY_ID    (4'h1),
    .BCAST_ID (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .pkt_source (pkt_source),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".count"}, 16'(fifo_count), 16'(sb_q.size()));
    checkOutput({tag, ".drops"}, 16'(drop_cnt), 16'(m_drops));
    checkOutput({tag, ".ovf"},   16'(overflow), 16'(m_ovf));
  endtask

  // One clock: drive inputs, check head/valid before the edge, update model, check state after.
  task automatic applyStimulus(input string tag, input logic [15:0] d, input logic v, input logic r);
    logic        pop_m;
    logic        match_m;
    logic [11:0] head;
    data_in   = d;
    valid_in  = v;
    pkt_ready = r;
    #1;
    checkOutput({tag, ".valid"}, 16'(pkt_valid), 16'(sb_q.size() > 0));
    pop_m   = (sb_q.size() > 0) && r;
    match_m = v && (d[11:8] == 4'h1 || d[11:8] == 4'hF);
    if (pop_m) begin
      head = sb_q.pop_front();
      checkOutput({tag, ".head"}, 16'({pkt_source, pkt_data}), 16'(head));
    end
    if (match_m) begin
      if (sb_q.size() < DEPTH) begin
        sb_q.push_back({d[15:12], d[7:0]});
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  task automatic doReset(input logic [15:0] d, input logic v);
    reset    = 1'b1;
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    sb_q.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = '0;
    valid_in  = 1'b0;
    pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset.valid", 16'(pkt_valid), 16'd0);
    checkOutput("reset.count", 16'(fifo_count), 16'd0);
    checkOutput("reset.drops", 16'(drop_cnt), 16'd0);
    checkOutput("reset.ovf",   16'(overflow), 16'd0);

    // Single packet, consumer always ready.
    applyStimulus("single", 16'h21A5, 1'b1, 1'b1);
    checkOutput("single.src",  16'(pkt_source), 16'h2);
    checkOutput("single.data", 16'(pkt_data), 16'hA5);
    applyStimulus("single", 16'h0000, 1'b0, 1'b1);
    applyStimulus("single", 16'h0000, 1'b0, 1'b1);

    // Filter: foreign target dropped silently, broadcast accepted once.
    applyStimulus("filter", 16'h2355, 1'b1, 1'b1);
    applyStimulus("filter", 16'h2F66, 1'b1, 1'b1);
    applyStimulus("filter", 16'h0000, 1'b0, 1'b1);
    applyStimulus("filter", 16'h0000, 1'b0, 1'b1);
    checkOutput("filter.drops", 16'(drop_cnt), 16'd0);

    // Overflow: 10 matching packets with no consumer.
    for (int i = 0; i < 10; i++) begin
      applyStimulus("ovfl", {4'h3, 4'h1, 8'(i)}, 1'b1, 1'b0);
    end
    checkOutput("ovfl.count8", 16'(fifo_count), 16'd8);
    checkOutput("ovfl.drops2", 16'(drop_cnt), 16'd2);
    checkOutput("ovfl.flag",   16'(overflow), 16'd1);

    // Full with simultaneous pop and push: no drop, occupancy unchanged.
    applyStimulus("fullpop", 16'h3155, 1'b1, 1'b1);
    checkOutput("fullpop.count8", 16'(fifo_count), 16'd8);
    checkOutput("fullpop.drops2", 16'(drop_cnt), 16'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("drain", 16'h0000, 1'b0, 1'b1);
    end

    // Back-to-back stream with a randomly stalling consumer.
    for (int i = 0; i < 40; i++) begin
      applyStimulus("stream", {4'(i), 4'h1, 8'(8'h80 + i)}, 1'b1, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus("sdrain", 16'h0000, 1'b0, 1'b1);
    end
    checkOutput("stream.empty", 16'(sb_q.size()), 16'd0);

    // Drop counter saturation.
    for (int i = 0; i < DEPTH + 260; i++) begin
      applyStimulus("sat", {4'h5, 4'hF, 8'(i)}, 1'b1, 1'b0);
    end
    checkOutput("sat.drops255", 16'(drop_cnt), 16'd255);

    // Reset mid-operation with 5 entries buffered; input during reset is ignored.
    doReset(16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("prerst", {4'h6, 4'h1, 8'(8'h40 + i)}, 1'b1, 1'b0);
    end
    checkOutput("prerst.count5", 16'(fifo_count), 16'd5);
    doReset(16'h71C3, 1'b1);
    checkOutput("rst.valid", 16'(pkt_valid), 16'd0);
    checkOutput("rst.count", 16'(fifo_count), 16'd0);
    checkOutput("rst.drops", 16'(drop_cnt), 16'd0);
    checkOutput("rst.ovf",   16'(overflow), 16'd0);
    applyStimulus("postrst", 16'h81D7, 1'b1, 1'b1);
    checkOutput("postrst.src",  16'(pkt_source), 16'h8);
    checkOutput("postrst.data", 16'(pkt_data), 16'hD7);
    applyStimulus("postrst", 16'h0000, 1'b0, 1'b1);
    applyStimulus("postrst", 16'h0000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/pds_egress_buffer.md
# pds_egress_buffer

Downstream egress stage of the packet data switch: consumes the switch's 16-bit output stream (`data_op`/`valid_op`, no backpressure) and keeps only packets addressed to this port or to broadcast. It buffers accepted packets in a synchronous FIFO and presents them to a local consumer over a ready/valid handshake. Overflow drops are counted and flagged.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `MY_ID`, 4'h1: target ID this port accepts.
- `BCAST_ID`, 4'hF: broadcast target ID, also accepted.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_in`  in  16  packet `{source[15:12], target[11:8], data[7:0]}`, driven by the switch's `data_op`.
- `valid_in`  in  1  `data_in` qualifier, driven by the switch's `valid_op`; single-cycle pulses, no stall possible.
- `pkt_source`  out  4  source field of the FIFO head.
- `pkt_data`  out  8  data field of the FIFO head.
- `pkt_valid`  out  1  FIFO non-empty.
- `pkt_ready`  in  1  consumer accepts the head when `pkt_valid & pkt_ready`.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `drop_cnt`  out  8  overflow drops, saturating at 255.
- `overflow`  out  1  sticky; set on the first drop, cleared only by reset.

## Operation
- Match: `match = valid_in & (target == MY_ID | target == BCAST_ID)`.
- Non-matching valid packets are ignored silently and are not counted.
- Push: `match & (!full | pop)`. The FIFO stores `{source, data}`, 12 bits; the target is not stored.
- Pop: `pkt_valid & pkt_ready`. The head advances at the clock edge.
- Drop: `match & full & !pop`. `drop_cnt` increments unless already 255, and `overflow` sets.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full.
  - `fifo_count` is unchanged and both pointers advance.
- Pop while empty cannot occur, because `pkt_ready` is ignored when `pkt_valid` = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `fifo_count`, not from pointer compare.
- `fifo_count` next value: +1 on push only, −1 on pop only, unchanged otherwise.
- Packet order is strictly preserved.
- No reordering, no duplication.
- A broadcast packet is accepted exactly once.
- Reset values: `pkt_valid`=0, `fifo_count`=0, `drop_cnt`=0, `overflow`=0, pointers=0.
  - `pkt_source`/`pkt_data` are don't-care while `pkt_valid`=0. The bench must not check them then.
- Reset mid-operation: all buffered packets are discarded. The input is ignored during the reset cycle.

## Timing
- Latency: a packet pushed at edge N appears on `pkt_valid`/`pkt_source`/`pkt_data` after edge N.
  - That is, it is visible in cycle N+1 when the FIFO was empty.
  - There is no combinational bypass from `data_in` to the outputs.
- Head outputs are read from storage indexed by the registered read pointer. They are stable until the pop edge.
- `pkt_valid` falls in the cycle after the pop of the last entry, unless a push lands on the same edge.
- Throughput: one push and one pop per cycle sustained.
- The consumer may hold `pkt_ready` high continuously. It may also toggle it freely, with no ordering requirement between `pkt_ready` and `pkt_valid`.
- `drop_cnt` and `overflow` update on the edge of the dropped packet and are visible the following cycle.

## Structure
- Package `pds_pkg`:
  - `typedef struct packed { logic [3:0] source; logic [3:0] target; logic [7:0] data; } pds_pkt_t`, matching the `drive_packet` packing.
  - `SRC_W`=4, `TGT_W`=4, `DATA_W`=8, `BCAST_ID_DEFAULT`=4'hF.
- Sub-module `pds_sync_fifo`:
  - Parameterised by `WIDTH` and `DEPTH`.
  - Contains the storage, pointers, count, push/pop/full/empty.
- The top level holds the match filter, the drop logic, the saturating counter and the sticky flag.

## Test plan
- Reset, then one packet 16'h21A5 (src 2, tgt 1, data A5) with `pkt_ready`=1:
  - `pkt_valid` is high exactly one cycle later with `pkt_source`=2 and `pkt_data`=A5.
  - `fifo_count` goes 0→1→0.
- Filter: send 16'h2355 (tgt 3) and 16'h2F66 (broadcast):
  - Only 66 is delivered.
  - `drop_cnt` stays 0.
- Overflow with `DEPTH`=8 and `pkt_ready`=0, sending 10 matching packets with data 00..09:
  - `fifo_count`=8, `drop_cnt`=2, `overflow`=1.
  - Draining yields 00..07 in order.
- Full plus simultaneous pop: hold full, then assert `pkt_ready` in the same cycle as a matching packet 0x55:
  - No drop, `fifo_count` stays 8.
  - The packet is delivered after the original 8.
- Wrap and back-to-back: stream 40 consecutive matching packets with random `pkt_ready`:
  - All 40 are received in order, with pointers wrapping ≥ 4 times and zero drops while occupancy stays < 8.
- Reset mid-operation with 5 entries buffered:
  - The cycle after reset shows `pkt_valid`=0, `fifo_count`=0, `drop_cnt`=0, `overflow`=0.
  - The next packet is delivered normally.
